// File: rtl/mem_arbiter_if.sv
// Bus bundle between the cacheline adapters, the arbiter and backing memory.
// The master side drives requests and the memory return; the slave side is the arbiter.
interface mem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_address;
  logic [NUM_PORTS-1:0]            p_read;
  logic [NUM_PORTS-1:0]            p_write;
  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata;
  logic [NUM_PORTS*DATA_WIDTH-1:0] p_rdata;
  logic [NUM_PORTS-1:0]            p_resp;
  logic [ADDR_WIDTH-1:0]           bmem_address;
  logic                            bmem_read;
  logic                            bmem_write;
  logic [DATA_WIDTH-1:0]           bmem_wdata;
  logic [DATA_WIDTH-1:0]           bmem_rdata;
  logic                            bmem_resp;
  logic [NUM_PORTS-1:0]            arb_grant;
  logic                            arb_busy;

  modport master (
    output p_address, p_read, p_write, p_wdata, bmem_rdata, bmem_resp,
    input  p_rdata, p_resp, bmem_address, bmem_read, bmem_write, bmem_wdata,
    input  arb_grant, arb_busy
  );

  modport slave (
    input  p_address, p_read, p_write, p_wdata, bmem_rdata, bmem_resp,
    output p_rdata, p_resp, bmem_address, bmem_read, bmem_write, bmem_wdata,
    output arb_grant, arb_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// N-port burst arbiter for a single backing memory: one owner per burst,
// round-robin or fixed priority, with a mandatory idle cycle between bursts.
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 4,
  parameter int RR_MODE    = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      owner_reg, owner_next;
  logic [IDX_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]      beat_reg, beat_next;
  logic [IDX_W-1:0]      pick;
  logic                  found;
  logic                  busy;
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  grant;
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

  assign busy = (state_reg == BUSY);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign req[gi]       = bus.p_read[gi] | bus.p_write[gi];
      assign addr_arr[gi]  = bus.p_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = bus.p_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign grant[gi]     = busy && (owner_reg == IDX_W'(gi));
    end
  endgenerate

  // Search starts at rr_ptr (or port 0) and wraps; first requester wins.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (RR_MODE != 0) ? int'(rr_ptr_reg) + k : k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && req[idx[IDX_W-1:0]]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    beat_next   = beat_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = BUSY;
          owner_next = pick;
          beat_next  = '0;
        end
      end
      BUSY: begin
        if (bus.bmem_resp) begin
          if (beat_reg == CNT_W'(BURST_LEN - 1)) begin
            state_next = IDLE;
            beat_next  = '0;
            if (RR_MODE != 0)
              rr_ptr_next = (owner_reg == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_reg + 1'b1;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      beat_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
      beat_reg   <= beat_next;
    end
  end

  // Memory side follows the owner combinationally; a read+write request is treated as a read.
  always_comb begin
    bus.bmem_address = '0;
    bus.bmem_read    = 1'b0;
    bus.bmem_write   = 1'b0;
    bus.bmem_wdata   = '0;
    if (busy) begin
      bus.bmem_address = addr_arr[owner_reg];
      bus.bmem_read    = bus.p_read[owner_reg];
      bus.bmem_write   = bus.p_write[owner_reg] & ~bus.p_read[owner_reg];
      bus.bmem_wdata   = wdata_arr[owner_reg];
    end
  end

  always_comb begin
    bus.p_resp  = '0;
    bus.p_rdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        bus.p_resp[i]                           = bus.bmem_resp;
        bus.p_rdata[i*DATA_WIDTH +: DATA_WIDTH] = bus.bmem_rdata;
      end
    end
  end

  assign bus.arb_grant = grant;
  assign bus.arb_busy  = busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three configurations run side by side against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic done_a = 1'b0, done_b = 1'b0, done_c = 1'b0;

  mem_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(64)) if_a ();
  mem_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(64)) if_b ();
  mem_arbiter_if #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)) if_c ();

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_LEN(4), .RR_MODE(1))
    dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_LEN(4), .RR_MODE(0))
    dut_b (.clk(clk), .rst(rst_b), .bus(if_b));
  mem_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_LEN(1), .RR_MODE(1))
    dut_c (.clk(clk), .rst(rst_c), .bus(if_c));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model state per instance (0=a, 1=b, 2=c)
  bit m_busy  [3];
  int m_owner [3];
  int m_beats [3];
  int m_rr    [3];
  int hist     [3][64];
  int hist_cyc [3][64];
  int hist_n   [3];

  task automatic lit(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_step(
    input int id, input int np, input int bl, input bit rrm, input logic rst_i,
    input logic [255:0] pa, input logic [7:0] prd, input logic [7:0] pwr,
    input logic [511:0] pwd, input logic [63:0] brd, input logic bresp,
    input logic [511:0] g_rdata, input logic [7:0] g_resp, input logic [31:0] g_addr,
    input logic g_rd, input logic g_wr, input logic [63:0] g_wd,
    input logic [7:0] g_grant, input logic g_busy);
    logic [7:0]   e_grant, e_resp;
    logic         e_busy, e_rd, e_wr;
    logic [31:0]  e_addr;
    logic [63:0]  e_wd;
    logic [511:0] e_rdata;
    logic [7:0]   reqs;
    int o, idx;
    e_grant = '0; e_resp = '0; e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
    e_addr = '0; e_wd = '0; e_rdata = '0;
    if (m_busy[id]) begin
      o       = m_owner[id];
      e_busy  = 1'b1;
      e_grant = 8'(1) << o;
      e_addr  = pa[o*32 +: 32];
      e_rd    = prd[o];
      e_wr    = pwr[o] & ~prd[o];
      e_wd    = pwd[o*64 +: 64];
      e_resp  = 8'(bresp) << o;
      e_rdata = 512'(brd) << (o*64);
    end
    n_checks++;
    if ({g_grant, g_busy} !== {e_grant, e_busy}) begin
      n_errors++;
      $display("FAIL grant[%0d] cyc %0d got %b/%b want %b/%b", id, cyc, g_grant, g_busy, e_grant, e_busy);
    end
    n_checks++;
    if ({g_addr, g_rd, g_wr, g_wd} !== {e_addr, e_rd, e_wr, e_wd}) begin
      n_errors++;
      $display("FAIL bmem[%0d] cyc %0d got %h %b %b %h want %h %b %b %h", id, cyc,
               g_addr, g_rd, g_wr, g_wd, e_addr, e_rd, e_wr, e_wd);
    end
    n_checks++;
    if ({g_resp, g_rdata} !== {e_resp, e_rdata}) begin
      n_errors++;
      $display("FAIL ret[%0d] cyc %0d got resp %b rdata %h want resp %b rdata %h", id, cyc,
               g_resp, g_rdata, e_resp, e_rdata);
    end
    // advance the model across the coming clock edge
    reqs = (prd | pwr) & 8'((1 << np) - 1);
    if (rst_i) begin
      m_busy[id] = 1'b0; m_beats[id] = 0; m_rr[id] = 0;
    end else if (!m_busy[id]) begin
      for (int k = 0; k < np; k++) begin
        idx = rrm ? (m_rr[id] + k) % np : k;
        if (!m_busy[id] && reqs[idx]) begin
          m_busy[id] = 1'b1; m_owner[id] = idx; m_beats[id] = 0;
          if (hist_n[id] < 64) begin
            hist[id][hist_n[id]]     = idx;
            hist_cyc[id][hist_n[id]] = cyc + 1;
            hist_n[id]++;
          end
        end
      end
    end else if (bresp) begin
      m_beats[id]++;
      if (m_beats[id] == bl) begin
        m_busy[id] = 1'b0; m_beats[id] = 0;
        if (rrm) m_rr[id] = (m_owner[id] + 1) % np;
      end
    end
  endtask

  always @(negedge clk) begin
    check_step(0, 2, 4, 1'b1, rst_a, 256'(if_a.p_address), 8'(if_a.p_read), 8'(if_a.p_write),
               512'(if_a.p_wdata), if_a.bmem_rdata, if_a.bmem_resp, 512'(if_a.p_rdata),
               8'(if_a.p_resp), if_a.bmem_address, if_a.bmem_read, if_a.bmem_write,
               if_a.bmem_wdata, 8'(if_a.arb_grant), if_a.arb_busy);
    check_step(1, 2, 4, 1'b0, rst_b, 256'(if_b.p_address), 8'(if_b.p_read), 8'(if_b.p_write),
               512'(if_b.p_wdata), if_b.bmem_rdata, if_b.bmem_resp, 512'(if_b.p_rdata),
               8'(if_b.p_resp), if_b.bmem_address, if_b.bmem_read, if_b.bmem_write,
               if_b.bmem_wdata, 8'(if_b.arb_grant), if_b.arb_busy);
    check_step(2, 4, 1, 1'b1, rst_c, 256'(if_c.p_address), 8'(if_c.p_read), 8'(if_c.p_write),
               512'(if_c.p_wdata), if_c.bmem_rdata, if_c.bmem_resp, 512'(if_c.p_rdata),
               8'(if_c.p_resp), if_c.bmem_address, if_c.bmem_read, if_c.bmem_write,
               if_c.bmem_wdata, 8'(if_c.arb_grant), if_c.arb_busy);
  end

  task automatic wait_idle(input int id, input string name);
    int n;
    n = 0;
    while (m_busy[id] && n < 40) begin
      tick();
      n++;
    end
    if (m_busy[id]) lit({name, "_timeout"}, 512'(1), 512'(0));
  endtask

  // Instance a: 2 ports, burst 4, round-robin
  initial begin : proc_a
    int base;
    rst_a = 1'b1;
    if_a.p_address = '0; if_a.p_read = '0; if_a.p_write = '0; if_a.p_wdata = '0;
    if_a.bmem_rdata = '0; if_a.bmem_resp = 1'b0;
    repeat (3) tick();
    rst_a = 1'b0;
    #2;
    lit("a_reset_grant", 512'(if_a.arb_grant), 512'(0));
    lit("a_reset_busy", 512'(if_a.arb_busy), 512'(0));
    // single read from port 1
    if_a.p_address[63:32] = 32'h1000;
    if_a.p_read = 2'b10;
    tick(); #2;
    lit("a_single_addr", 512'(if_a.bmem_address), 512'(32'h1000));
    lit("a_single_read", 512'(if_a.bmem_read), 512'(1));
    lit("a_single_grant", 512'(if_a.arb_grant), 512'(2'b10));
    if_a.p_read = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      if_a.bmem_resp = 1'b1;
      if_a.bmem_rdata = {$urandom, $urandom};
    end
    tick(); #2;
    lit("a_single_done", 512'(if_a.arb_busy), 512'(0));
    lit("a_stray_resp", 512'(if_a.p_resp), 512'(0));
    lit("a_single_hist", 512'(hist[0][0]), 512'(1));
    // contention with continuous responses
    base = hist_n[0];
    if_a.p_read = 2'b11;
    for (int n = 0; n < 60 && hist_n[0] < base + 4; n++) tick();
    if_a.p_read = 2'b00;
    wait_idle(0, "a_contention");
    if_a.bmem_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lit($sformatf("a_rr_order%0d", i), 512'(hist[0][base+i]), 512'(i % 2));
      if (i > 0)
        lit($sformatf("a_rr_gap%0d", i), 512'(hist_cyc[0][base+i] - hist_cyc[0][base+i-1]), 512'(5));
    end
    // mid-burst drop by the owner
    base = hist_n[0];
    if_a.p_read = 2'b11;
    tick();
    if_a.bmem_resp = 1'b1;
    tick();
    tick();
    if_a.p_read = 2'b10;
    tick(); #2;
    lit("a_drop_held", 512'(if_a.arb_grant), 512'(2'b01));
    tick();
    if_a.bmem_resp = 1'b0;
    tick();
    lit("a_drop_first", 512'(hist[0][base]), 512'(0));
    lit("a_drop_second", 512'(hist[0][base+1]), 512'(1));
    lit("a_drop_gap", 512'(hist_cyc[0][base+1] - hist_cyc[0][base]), 512'(5));
    // reset during port 1's burst, rr pointer was 1
    if_a.bmem_resp = 1'b1;
    tick();
    if_a.bmem_resp = 1'b0;
    rst_a = 1'b1;
    if_a.p_read = 2'b11;
    tick();
    rst_a = 1'b0;
    #2;
    lit("a_rst_grant", 512'(if_a.arb_grant), 512'(0));
    lit("a_rst_outs", 512'({if_a.arb_busy, if_a.bmem_read, if_a.bmem_address, if_a.p_resp}), 512'(0));
    tick(); #2;
    lit("a_rst_regrant", 512'(if_a.arb_grant), 512'(2'b01));
    if_a.p_read = 2'b00;
    if_a.bmem_resp = 1'b1;
    wait_idle(0, "a_rst");
    // randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      tick();
      if_a.p_read     = 2'($urandom);
      if_a.p_write    = 2'($urandom);
      if_a.p_address  = {$urandom, $urandom};
      if_a.p_wdata    = {$urandom, $urandom, $urandom, $urandom};
      if_a.bmem_rdata = {$urandom, $urandom};
      if_a.bmem_resp  = ($urandom_range(0, 2) != 0);
      rst_a           = ($urandom_range(0, 63) == 0);
    end
    tick();
    rst_a = 1'b0;
    done_a = 1'b1;
  end

  // Instance b: 2 ports, burst 4, fixed priority
  initial begin : proc_b
    int ones;
    rst_b = 1'b1;
    if_b.p_address = '0; if_b.p_read = '0; if_b.p_write = '0; if_b.p_wdata = '0;
    if_b.bmem_rdata = '0; if_b.bmem_resp = 1'b0;
    repeat (3) tick();
    rst_b = 1'b0;
    if_b.p_read = 2'b11;
    if_b.p_write = 2'b01;
    if_b.p_address = {32'h2222_0000, 32'h1111_0000};
    if_b.bmem_resp = 1'b1;
    tick(); #2;
    lit("b_rw_write_forced", 512'({if_b.bmem_read, if_b.bmem_write}), 512'(2'b10));
    lit("b_addr", 512'(if_b.bmem_address), 512'(32'h1111_0000));
    repeat (39) tick();
    if_b.p_read = 2'b00;
    if_b.p_write = 2'b00;
    wait_idle(1, "b_prio");
    ones = 0;
    for (int i = 0; i < hist_n[1]; i++) ones += hist[1][i];
    lit("b_grant_count", 512'(hist_n[1]), 512'(8));
    lit("b_port1_grants", 512'(ones), 512'(0));
    for (int n = 0; n < 400; n++) begin
      tick();
      if_b.p_read     = 2'($urandom);
      if_b.p_write    = 2'($urandom);
      if_b.p_address  = {$urandom, $urandom};
      if_b.p_wdata    = {$urandom, $urandom, $urandom, $urandom};
      if_b.bmem_rdata = {$urandom, $urandom};
      if_b.bmem_resp  = ($urandom_range(0, 3) != 0);
      rst_b           = ($urandom_range(0, 99) == 0);
    end
    tick();
    rst_b = 1'b0;
    done_b = 1'b1;
  end

  // Instance c: 4 ports, single-beat bursts, round-robin
  initial begin : proc_c
    rst_c = 1'b1;
    if_c.p_address = '0; if_c.p_read = '0; if_c.p_write = '0; if_c.p_wdata = '0;
    if_c.bmem_rdata = '0; if_c.bmem_resp = 1'b0;
    repeat (3) tick();
    rst_c = 1'b0;
    if_c.p_read = 4'hF;
    if_c.bmem_resp = 1'b1;
    for (int n = 0; n < 30 && hist_n[2] < 4; n++) tick();
    if_c.p_read = 4'h0;
    wait_idle(2, "c_four");
    for (int i = 0; i < 4; i++) begin
      lit($sformatf("c_order%0d", i), 512'(hist[2][i]), 512'(i));
      if (i > 0)
        lit($sformatf("c_gap%0d", i), 512'(hist_cyc[2][i] - hist_cyc[2][i-1]), 512'(2));
    end
    for (int n = 0; n < 400; n++) begin
      tick();
      if_c.p_read     = 4'($urandom);
      if_c.p_write    = 4'($urandom);
      if_c.p_address  = {$urandom, $urandom, $urandom, $urandom};
      if_c.p_wdata    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if_c.bmem_rdata = {$urandom, $urandom};
      if_c.bmem_resp  = ($urandom_range(0, 1) != 0);
      rst_c           = ($urandom_range(0, 79) == 0);
    end
    tick();
    rst_c = 1'b0;
    done_c = 1'b1;
  end

  initial begin : proc_main
    int n;
    n = 0;
    while (!(done_a && done_b && done_c) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (!(done_a && done_b && done_c)) lit("run_timeout", 512'(1), 512'(0));
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requesting cacheline adapters; legal range 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: memory address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: memory beat width.
REQ-004 SHALL have parameter BURST_LEN, default 4: number of bmem_resp beats per transaction; legal range 1..16.
REQ-005 SHALL have parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority with port 0 highest.
REQ-006 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-008 SHALL have ports p_address, p_read, p_write and p_wdata as inputs of widths NUM_PORTS*ADDR_WIDTH, NUM_PORTS, NUM_PORTS and NUM_PORTS*DATA_WIDTH: per-port request buses, with port i in slice i.
REQ-009 SHALL have ports p_rdata and p_resp as outputs of widths NUM_PORTS*DATA_WIDTH and NUM_PORTS: per-port return data and beat response.
REQ-010 SHALL have ports bmem_address, bmem_read, bmem_write and bmem_wdata as outputs of widths ADDR_WIDTH, 1, 1 and DATA_WIDTH: memory-side request.
REQ-011 SHALL have ports bmem_rdata and bmem_resp as inputs of widths DATA_WIDTH and 1: memory-side return.
REQ-012 SHALL have ports arb_grant and arb_busy as outputs of widths NUM_PORTS and 1: one-hot current owner and transaction-in-progress flag.

Function
REQ-013 SHALL implement a two-state FSM with states IDLE and BUSY.
REQ-014 In IDLE, a port SHALL count as requesting when p_read[i] or p_write[i] is high.
REQ-015 In IDLE with at least one requester, the arbiter SHALL select one requester and enter BUSY on the next edge, registering the winner in arb_grant; arb_busy SHALL then be 1.
REQ-016 With RR_MODE=1, selection SHALL start from rr_ptr and search upward with wrap-around from NUM_PORTS-1 to 0.
REQ-017 With RR_MODE=0, selection SHALL pick the lowest-index requester.
REQ-018 In IDLE, bmem_read, bmem_write, bmem_address, bmem_wdata, all p_resp, all p_rdata, arb_grant and arb_busy SHALL be 0; there is no same-cycle pass-through and the minimum grant latency is 1 cycle.
REQ-019 In BUSY, bmem_address, bmem_read, bmem_write and bmem_wdata SHALL be driven combinationally from the granted port's slice.
REQ-020 If the granted port raises both read and write, bmem_write SHALL be forced to 0.
REQ-021 In BUSY, the granted port SHALL receive p_resp = bmem_resp and p_rdata = bmem_rdata; all other ports SHALL receive 0 on both.
REQ-022 A beat counter of width clog2(BURST_LEN+1) SHALL increment on each bmem_resp seen in BUSY.
REQ-023 On the bmem_resp that brings the count to BURST_LEN, the FSM SHALL return to IDLE on that edge and clear the counter.
REQ-024 On that same completion edge with RR_MODE=1, rr_ptr SHALL become (granted index + 1) mod NUM_PORTS.
REQ-025 The grant SHALL be held until burst completion even if the granted port deasserts its request mid-burst, so no other port is granted mid-burst.
REQ-026 Requests from non-granted ports SHALL be ignored during BUSY and SHALL be serviced only after the mandatory IDLE cycle that follows completion.
REQ-027 A bmem_resp arriving in IDLE SHALL be ignored and SHALL not be forwarded.
REQ-028 arb_grant SHALL always be one-hot in BUSY and all-zero in IDLE.

Reset
REQ-029 While rst=1 at a clock edge: state SHALL become IDLE, the beat counter 0, rr_ptr 0 and arb_grant 0, including when rst is asserted mid-burst.
REQ-030 After reset, all outputs SHALL equal the IDLE values of REQ-018.
REQ-031 An in-flight burst aborted by reset SHALL not be resumed.

Verification
REQ-032 Single read: NUM_PORTS=2; port 1 raises read to address 0x1000 -> next cycle bmem_address=0x1000, bmem_read=1, arb_grant=2'b10; 4 resp beats forwarded only to port 1; IDLE after the 4th.
REQ-033 Contention, RR_MODE=1: ports 0 and 1 request continuously -> grants alternate 0,1,0,1, each separated by exactly one IDLE cycle.
REQ-034 Fixed priority, RR_MODE=0: ports 0 and 1 request continuously -> port 0 is granted every transaction and port 1 is never granted.
REQ-035 Mid-burst drop: granted port deasserts read after beat 2 -> grant held through beat 4; the other requester is granted 2 cycles after beat 4.
REQ-036 Reset mid-burst: rst after beat 1 -> next cycle all outputs 0 and arb_grant=0; a new request is granted from rr_ptr=0.
REQ-037 Stray response and width: bmem_resp pulsed in IDLE -> no p_resp; NUM_PORTS=4, BURST_LEN=1 -> 4 requesters are granted 0,1,2,3 in order, each completing on its single beat.
